// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode/direction types and sizing helpers for the multi-channel PWM
package pwm_pkg;
    typedef enum logic {EDGE = 1'b0, CENTER = 1'b1} pwm_mode_e;
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction
    function automatic int dt_width(input int dt);
        return (dt < 1) ? 1 : $clog2(dt + 1);
    endfunction
endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary hi/lo gate pair, both held low for DT clk after every raw edge
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_raw,
    output logic o_hi,
    output logic o_lo
);
    localparam int DTW = dt_width(DT);
    localparam logic [DTW-1:0] DT_V = DTW'(DT);
    logic           r_raw_d;
    logic [DTW-1:0] r_dt_cnt;
    logic [DTW-1:0] w_dt_nxt;
    logic           w_pass;
    always_comb begin
        w_dt_nxt = (i_raw != r_raw_d) ? DT_V : (r_dt_cnt != '0) ? r_dt_cnt - DTW'(1) : '0;
        w_pass   = (w_dt_nxt == '0);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_raw_d  <= 1'b0;
            r_dt_cnt <= '0;
            o_hi     <= 1'b0;
            o_lo     <= 1'b0;
        end else if (!i_en) begin
            r_raw_d  <= 1'b0;
            r_dt_cnt <= '0;
            o_hi     <= 1'b0;
            o_lo     <= 1'b0;
        end else begin
            r_raw_d  <= i_raw;
            r_dt_cnt <= w_dt_nxt;
            o_hi     <= w_pass && i_raw;
            o_lo     <= w_pass && !i_raw;
        end
endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: N-channel PWM with shared edge/center counter, double-buffered duty and dead-time
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int W    = 11,
    parameter int DT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  pwm_mode_e         i_mode,
    input  logic              i_duty_wr,
    input  logic [N_CH*W-1:0] i_duty,
    output logic [N_CH-1:0]   o_pwm_hi,
    output logic [N_CH-1:0]   o_pwm_lo,
    output logic              o_period_sync
);
    localparam logic [W-1:0] MAX = W'(cnt_max(W));
    logic [W-1:0]      r_cnt;
    logic [W-1:0]      w_cnt_nxt;
    dir_e              r_dir;
    dir_e              w_dir_nxt;
    pwm_mode_e         r_mode_act;
    logic [N_CH*W-1:0] r_shadow;
    logic [N_CH*W-1:0] r_active;
    logic [N_CH*W-1:0] w_act;
    logic [N_CH-1:0]   r_raw;
    logic [N_CH-1:0]   w_raw;
    logic              w_bnd;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_cnt <= '0;
            r_dir <= UP;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
        end

    always_comb begin
        w_bnd     = i_en && (r_cnt == '0);
        w_cnt_nxt = r_cnt + W'(1);
        w_dir_nxt = UP;
        if (!i_en)
            w_cnt_nxt = '0;
        else if (!w_bnd && r_mode_act == CENTER && (r_dir == DOWN || r_cnt == MAX)) begin
            w_cnt_nxt = r_cnt - W'(1);
            w_dir_nxt = (r_cnt == W'(1)) ? UP : DOWN;
        end
    end

    // the boundary count already belongs to the new period, so it compares against the incoming duty
    always_comb begin
        w_act = w_bnd ? r_shadow : r_active;
        w_raw = '0;
        for (int k = 0; k < N_CH; k++)
            w_raw[k] = i_en && (r_cnt < w_act[k*W +: W]);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_mode_act    <= EDGE;
            r_shadow      <= '0;
            r_active      <= '0;
            r_raw         <= '0;
            o_period_sync <= 1'b0;
        end else begin
            r_raw         <= w_raw;
            o_period_sync <= w_bnd;
            if (i_duty_wr)
                r_shadow <= i_duty;
            if (w_bnd) begin
                r_active   <= r_shadow;
                r_mode_act <= i_mode;
            end
        end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_deadtime #(.DT(DT)) u_dt (
            .clk   (clk),
            .rst   (rst),
            .i_en  (i_en),
            .i_raw (r_raw[k]),
            .o_hi  (o_pwm_hi[k]),
            .o_lo  (o_pwm_lo[k])
        );
    end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: scoreboard bench for pwm_multi_ch, DT=2 and DT=3 instances on shared stimulus
module tb_pwm_multi_ch;
    import pwm_pkg::*;
    localparam int N  = 3;
    localparam int W  = 4;
    localparam int MX = 15;
    logic           clk  = 1'b0;
    logic           rst  = 1'b1;
    logic           en   = 1'b0;
    logic           wr   = 1'b0;
    pwm_mode_e      mode = EDGE;
    logic [N*W-1:0] duty = '0;
    logic [N-1:0]   hi_a, lo_a, hi_b, lo_b;
    logic           sync_a, sync_b;
    typedef struct packed {
        logic [N-1:0] hi_a;
        logic [N-1:0] lo_a;
        logic [N-1:0] hi_b;
        logic [N-1:0] lo_b;
        logic         sync;
        logic [W-1:0] cnt;
    } exp_t;
    exp_t         sb[$];
    int           n_chk = 0;
    int           n_err = 0;
    int           ph = 0;
    pwm_mode_e    m_mode = EDGE;
    int           m_sh[N];
    int           m_act[N];
    logic [N-1:0] rh[8];
    int           c_hia[N], c_loa[N], c_hib[N], c_lob[N], c_raw[N];
    int           c_sync;

    always #5 clk = ~clk;

    pwm_multi_ch #(.N_CH(N), .W(W), .DT(2)) u_a (
        .clk(clk), .rst(rst), .i_en(en), .i_mode(mode), .i_duty_wr(wr), .i_duty(duty),
        .o_pwm_hi(hi_a), .o_pwm_lo(lo_a), .o_period_sync(sync_a)
    );
    pwm_multi_ch #(.N_CH(N), .W(W), .DT(3)) u_b (
        .clk(clk), .rst(rst), .i_en(en), .i_mode(mode), .i_duty_wr(wr), .i_duty(duty),
        .o_pwm_hi(hi_b), .o_pwm_lo(lo_b), .o_period_sync(sync_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    // CENTER is a 30-step phase folded into a triangle; EDGE is the phase itself
    function automatic int mcnt();
        return (m_mode == CENTER && ph > MX) ? 2*MX - ph : ph;
    endfunction

    // a gate is on only if raw has been steady for the last d+1 cycles
    function automatic logic [N-1:0] gate(input int d, input logic pol);
        logic [N-1:0] o;
        logic         stable;
        o = '0;
        for (int k = 0; k < N; k++) begin
            stable = 1'b1;
            for (int j = 1; j <= d; j++)
                if (rh[j][k] != rh[0][k]) stable = 1'b0;
            o[k] = stable && (rh[0][k] == pol);
        end
        return o;
    endfunction

    task automatic step();
        exp_t         e;
        int           cc;
        logic         bnd;
        logic [N-1:0] nraw;
        e = '0;
        nraw = '0;
        if (rst) begin
            ph = 0;
            m_mode = EDGE;
            for (int k = 0; k < N; k++) begin
                m_sh[k] = 0;
                m_act[k] = 0;
            end
            for (int j = 0; j < 8; j++) rh[j] = '0;
        end else begin
            cc = mcnt();
            bnd = en && (cc == 0);
            for (int k = 0; k < N; k++)
                nraw[k] = en && (cc < (bnd ? m_sh[k] : m_act[k]));
            if (en) begin
                e.hi_a = gate(2, 1'b1);
                e.lo_a = gate(2, 1'b0);
                e.hi_b = gate(3, 1'b1);
                e.lo_b = gate(3, 1'b0);
            end
            e.sync = bnd;
            if (bnd) begin
                m_mode = mode;
                for (int k = 0; k < N; k++) m_act[k] = m_sh[k];
            end
            if (wr)
                for (int k = 0; k < N; k++) m_sh[k] = int'(duty[k*W +: W]);
            ph = !en ? 0 : bnd ? 1 : (ph + 1) % (m_mode == CENTER ? 2*MX : MX + 1);
            for (int j = 7; j > 0; j--) rh[j] = rh[j-1];
            rh[0] = nraw;
            e.cnt = W'(mcnt());
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("hi_a", hi_a, e.hi_a);
        chk("lo_a", lo_a, e.lo_a);
        chk("hi_b", hi_b, e.hi_b);
        chk("lo_b", lo_b, e.lo_b);
        chk("sync_a", sync_a, e.sync);
        chk("sync_b", sync_b, e.sync);
        chk("cnt", u_a.r_cnt, e.cnt);
        chk("ovl_a", hi_a & lo_a, 0);
        chk("ovl_b", hi_b & lo_b, 0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr_duty(input logic [W-1:0] d2, input logic [W-1:0] d1, input logic [W-1:0] d0);
        duty = {d2, d1, d0};
        wr = 1'b1;
        step();
        wr = 1'b0;
    endtask

    task automatic measure(input int len);
        int g;
        g = 0;
        while (!sync_a && g < 64) begin
            step();
            g++;
        end
        chk("align", sync_a, 1);
        c_sync = 0;
        for (int k = 0; k < N; k++) begin
            c_hia[k] = 0; c_loa[k] = 0; c_hib[k] = 0; c_lob[k] = 0; c_raw[k] = 0;
        end
        for (int i = 0; i < len; i++) begin
            if (i > 0) step();
            c_sync += int'(sync_a);
            for (int k = 0; k < N; k++) begin
                c_hia[k] += int'(hi_a[k]);
                c_loa[k] += int'(lo_a[k]);
                c_hib[k] += int'(hi_b[k]);
                c_lob[k] += int'(lo_b[k]);
                c_raw[k] += int'(u_a.r_raw[k]);
            end
        end
    endtask

    initial begin
        int g;
        run(2);
        chk("rst_cnt", u_a.r_cnt, 0);
        chk("rst_hi", hi_a, 0);
        chk("rst_lo", lo_a, 0);
        chk("rst_sync", sync_a, 0);
        rst = 1'b0;
        wr_duty(15, 8, 4);
        en = 1'b1;
        run(40);
        measure(16);
        chk("t1_hi0", c_hia[0], 2);
        chk("t1_hi1", c_hia[1], 6);
        chk("t1_hi2", c_hia[2], 13);
        chk("t1_lo0", c_loa[0], 10);
        chk("t1_lo1", c_loa[1], 6);
        chk("t1_lo2", c_loa[2], 0);
        chk("t1_sync", c_sync, 1);
        chk("t1_hib0", c_hib[0], 1);
        chk("t1_lob0", c_lob[0], 9);
        mode = CENTER;
        wr_duty(0, 0, 5);
        run(70);
        measure(30);
        chk("t2_raw0", c_raw[0], 9);
        chk("t2_hi0", c_hia[0], 7);
        chk("t2_lo0", c_loa[0], 19);
        chk("t2_sync", c_sync, 1);
        step();
        chk("t2_period", sync_a, 1);
        mode = EDGE;
        run(70);
        measure(16);
        chk("t3_pre", c_raw[0], 5);
        run(5);
        wr_duty(0, 0, 9);
        measure(16);
        chk("t3_p1", c_raw[0], 9);
        chk("t3_at_bnd", u_a.r_cnt, 0);
        wr_duty(0, 0, 3);
        measure(16);
        chk("t3_p2", c_raw[0], 9);
        measure(16);
        chk("t3_p3", c_raw[0], 3);
        wr_duty(0, 0, 2);
        run(40);
        measure(16);
        chk("t4_hib0", c_hib[0], 0);
        chk("t4_lob0", c_lob[0], 11);
        chk("t4_hia0", c_hia[0], 0);
        chk("t4_loa0", c_loa[0], 12);
        wr_duty(15, 8, 4);
        run(40);
        measure(16);
        run(4);
        chk("t5_mid", hi_a[0], 1);
        en = 1'b0;
        step();
        chk("t5_off_hi", hi_a, 0);
        chk("t5_off_lo", lo_a, 0);
        chk("t5_off_cnt", u_a.r_cnt, 0);
        chk("t5_off_raw", u_a.r_raw, 0);
        wr_duty(0, 0, 7);
        run(7);
        en = 1'b1;
        step();
        chk("t5_sync", sync_a, 1);
        measure(16);
        chk("t5_raw0", c_raw[0], 7);
        mode = CENTER;
        run(40);
        g = 0;
        while (u_a.r_dir != DOWN && g < 64) begin
            step();
            g++;
        end
        chk("t6_down", u_a.r_dir, DOWN);
        run(3);
        rst = 1'b1;
        step();
        chk("t6_cnt", u_a.r_cnt, 0);
        chk("t6_dir", u_a.r_dir, UP);
        chk("t6_mode", u_a.r_mode_act, EDGE);
        chk("t6_hi", hi_a, 0);
        chk("t6_lo", lo_a, 0);
        rst = 1'b0;
        run(40);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
